// File: rtl/spad_req_arbiter_if.sv
// Request/response bundle of the scratchpad request arbiter: requester-side
// handshake plus the registered write and read channel outputs.
interface spad_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DESC_W  = 64,
  parameter int DATA_W  = 128
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DESC_W-1:0] req_desc;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_stall;

  logic                      w_stall;
  logic                      r_stall;

  logic                      wr_out_valid;
  logic [SRC_W-1:0]          wr_out_src;
  logic [DESC_W-1:0]         wr_out_desc;
  logic [DATA_W-1:0]         wr_out_wdata;

  logic                      rd_out_valid;
  logic [SRC_W-1:0]          rd_out_src;
  logic [DESC_W-1:0]         rd_out_desc;

  // Arbiter side.
  modport slave (
    input  req_valid, req_write, req_desc, req_wdata, w_stall, r_stall,
    output req_stall,
    output wr_out_valid, wr_out_src, wr_out_desc, wr_out_wdata,
    output rd_out_valid, rd_out_src, rd_out_desc
  );

  // Requester / downstream side.
  modport master (
    output req_valid, req_write, req_desc, req_wdata, w_stall, r_stall,
    input  req_stall,
    input  wr_out_valid, wr_out_src, wr_out_desc, wr_out_wdata,
    input  rd_out_valid, rd_out_src, rd_out_desc
  );
endinterface

// File: rtl/spad_req_arbiter.sv
// Scratchpad request arbiter: per-requester skid FIFOs feeding independent
// fixed-priority write and read channels. Define SPAD_REQ_ARB_AGING_EN for anti-starvation aging.
module spad_req_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DESC_W       = 64,
  parameter int DATA_W       = 128,
  parameter int SKID_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                CLK,
  input  logic                nRST,
  spad_req_arbiter_if.slave   bus
);

  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W   = $clog2(SKID_DEPTH);
  localparam int CNT_W   = $clog2(SKID_DEPTH + 1);
  localparam int ENTRY_W = 1 + DESC_W + DATA_W;

  // Handshake: a request transfers on a cycle with req_valid[i]=1 and
  // req_stall[i]=0; otherwise the requester holds it. A channel output is
  // consumed downstream on every cycle its stall input is 0.

  if (SKID_DEPTH < 2 || (SKID_DEPTH & (SKID_DEPTH - 1)) != 0 || STARVE_LIMIT < 1)
  begin : g_bad_param
    $error("spad_req_arbiter: SKID_DEPTH must be a power of two >= 2, STARVE_LIMIT >= 1");
  end

  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_elig_wr;
  logic [NUM_REQ-1:0] w_elig_rd;
  logic [NUM_REQ-1:0] w_starved;
  logic [DESC_W-1:0]  w_head_desc [NUM_REQ];
  logic [DATA_W-1:0]  w_head_data [NUM_REQ];

  logic               w_wr_vld;
  logic [SRC_W-1:0]   w_wr_win;
  logic               w_wr_grant;
  logic               w_rd_vld;
  logic [SRC_W-1:0]   w_rd_win;
  logic               w_rd_grant;

  logic               r_wr_valid;
  logic [SRC_W-1:0]   r_wr_src;
  logic [DESC_W-1:0]  r_wr_desc;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_rd_valid;
  logic [SRC_W-1:0]   r_rd_src;
  logic [DESC_W-1:0]  r_rd_desc;

  // ---------------------------------------------------------------------
  // Per-requester in-order FIFOs
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic [ENTRY_W-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [ENTRY_W-1:0] w_head;
    logic               w_nonempty;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_nonempty  = (r_cnt != '0);
    assign w_full[g]   = (r_cnt == CNT_W'(SKID_DEPTH));
    assign w_elig_wr[g] = w_nonempty &  w_head[ENTRY_W-1];
    assign w_elig_rd[g] = w_nonempty & ~w_head[ENTRY_W-1];
    assign w_head_desc[g] = w_head[DATA_W +: DESC_W];
    assign w_head_data[g] = w_head[DATA_W-1:0];

    assign w_push[g] = bus.req_valid[g] & ~w_full[g];
    assign w_pop[g]  = (w_wr_grant & (w_wr_win == SRC_W'(g))) |
                       (w_rd_grant & (w_rd_win == SRC_W'(g)));

    // Pointers wrap naturally because SKID_DEPTH is a power of two.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_cnt <= r_cnt + CNT_W'(w_push[g]) - CNT_W'(w_pop[g]);
      end
    end

    // Storage needs no reset: an entry is only read while the count covers it.
    always_ff @(posedge CLK) begin
      if (w_push[g]) begin
        r_mem[r_wr_ptr] <= {bus.req_write[g],
                            bus.req_desc[g*DESC_W +: DESC_W],
                            bus.req_wdata[g*DATA_W +: DATA_W]};
      end
    end
  end

  assign bus.req_stall = w_full;

  // ---------------------------------------------------------------------
  // Aging
  // ---------------------------------------------------------------------
`ifdef SPAD_REQ_ARB_AGING_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [AGE_W-1:0] r_age [NUM_REQ];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_REQ; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_pop[i]) begin
          r_age[i] <= '0;
        end else if (((w_elig_wr[i] & ~bus.w_stall) | (w_elig_rd[i] & ~bus.r_stall)) &&
                     (r_age[i] != AGE_W'(STARVE_LIMIT))) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_REQ; i++) w_starved[i] = (r_age[i] == AGE_W'(STARVE_LIMIT));
  end
`else
  assign w_starved = '0;
`endif

  // ---------------------------------------------------------------------
  // Channel arbitration: highest index wins, unless someone is starved, in
  // which case the lowest-index starved requester wins.
  // ---------------------------------------------------------------------
  function automatic logic [SRC_W:0] f_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [NUM_REQ-1:0] starved);
    logic [SRC_W:0] res;
    logic           found_s;
    res     = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i]) res = {1'b1, SRC_W'(i)};
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i] && starved[i] && !found_s) begin
        res     = {1'b1, SRC_W'(i)};
        found_s = 1'b1;
      end
    end
    return res;
  endfunction

  // A head is either a write or a read, so the two winners never collide.
  assign {w_wr_vld, w_wr_win} = f_pick(w_elig_wr, w_starved);
  assign {w_rd_vld, w_rd_win} = f_pick(w_elig_rd, w_starved);

  assign w_wr_grant = w_wr_vld & ~bus.w_stall;
  assign w_rd_grant = w_rd_vld & ~bus.r_stall;

  // ---------------------------------------------------------------------
  // Registered channel outputs, frozen while the channel is stalled
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_valid <= 1'b0;
      r_wr_src   <= '0;
      r_wr_desc  <= '0;
      r_wr_data  <= '0;
    end else if (!bus.w_stall) begin
      r_wr_valid <= w_wr_vld;
      if (w_wr_vld) begin
        r_wr_src  <= w_wr_win;
        r_wr_desc <= w_head_desc[w_wr_win];
        r_wr_data <= w_head_data[w_wr_win];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_valid <= 1'b0;
      r_rd_src   <= '0;
      r_rd_desc  <= '0;
    end else if (!bus.r_stall) begin
      r_rd_valid <= w_rd_vld;
      if (w_rd_vld) begin
        r_rd_src  <= w_rd_win;
        r_rd_desc <= w_head_desc[w_rd_win];
      end
    end
  end

  assign bus.wr_out_valid = r_wr_valid;
  assign bus.wr_out_src   = r_wr_src;
  assign bus.wr_out_desc  = r_wr_desc;
  assign bus.wr_out_wdata = r_wr_data;
  assign bus.rd_out_valid = r_rd_valid;
  assign bus.rd_out_src   = r_rd_src;
  assign bus.rd_out_desc  = r_rd_desc;

endmodule

// File: tb/tb_spad_req_arbiter.sv
// Self-checking bench for spad_req_arbiter: queue-based reference model with a
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_spad_req_arbiter;

  localparam int NR    = 2;
  localparam int DW    = 64;
  localparam int XW    = 128;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  spad_req_arbiter_if #(.NUM_REQ(NR), .DESC_W(DW), .DATA_W(XW)) bus ();

  spad_req_arbiter #(
    .NUM_REQ(NR), .DESC_W(DW), .DATA_W(XW),
    .SKID_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          w;
    logic [DW-1:0] d;
    logic [XW-1:0] x;
  } ent_t;

  typedef struct packed {
    logic          wv;
    logic          ws;
    logic [DW-1:0] wd;
    logic [XW-1:0] wx;
    logic          rv;
    logic          rs;
    logic [DW-1:0] rd;
    logic [NR-1:0] st;
  } snap_t;

  ent_t  m_q [NR][$];
  int    m_age [NR];
  snap_t m_out;
  snap_t exp_q [$];
  ent_t  m_e;
  logic [NR-1:0] m_elw, m_elr, m_full;
  int    m_ww, m_rw, m_gw, m_gr;

  // Fixed priority to the highest index; starved requesters first, lowest index.
  function automatic int pick(input logic [NR-1:0] el);
    int r;
    r = -1;
    for (int i = NR - 1; i >= 0; i--) if (el[i] && r < 0) r = i;
`ifdef SPAD_REQ_ARB_AGING_EN
    for (int i = NR - 1; i >= 0; i--) if (el[i] && m_age[i] == LIMIT) r = i;
`endif
    return r;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NR; i++) begin
        m_q[i].delete();
        m_age[i] = 0;
      end
      m_out = '0;
      exp_q.delete();
      exp_q.push_back(m_out);
    end else begin
      for (int i = 0; i < NR; i++) begin
        m_full[i] = (m_q[i].size() == DEPTH);
        m_elw[i]  = (m_q[i].size() > 0) && m_q[i][0].w;
        m_elr[i]  = (m_q[i].size() > 0) && !m_q[i][0].w;
      end
      m_ww = pick(m_elw);
      m_rw = pick(m_elr);
      m_gw = (!bus.w_stall && m_ww >= 0) ? m_ww : -1;
      m_gr = (!bus.r_stall && m_rw >= 0) ? m_rw : -1;
      if (!bus.w_stall) begin
        m_out.wv = (m_ww >= 0);
        if (m_ww >= 0) begin
          m_out.ws = m_ww[0];
          m_out.wd = m_q[m_ww][0].d;
          m_out.wx = m_q[m_ww][0].x;
        end
      end
      if (!bus.r_stall) begin
        m_out.rv = (m_rw >= 0);
        if (m_rw >= 0) begin
          m_out.rs = m_rw[0];
          m_out.rd = m_q[m_rw][0].d;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (i == m_gw || i == m_gr) m_age[i] = 0;
        else if ((m_elw[i] && !bus.w_stall) || (m_elr[i] && !bus.r_stall))
          m_age[i] = (m_age[i] + 1 > LIMIT) ? LIMIT : m_age[i] + 1;
      end
      if (m_gw >= 0) void'(m_q[m_gw].pop_front());
      if (m_gr >= 0) void'(m_q[m_gr].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && !m_full[i]) begin
          m_e.w = bus.req_write[i];
          m_e.d = bus.req_desc[i*DW +: DW];
          m_e.x = bus.req_wdata[i*XW +: XW];
          m_q[i].push_back(m_e);
        end
        m_out.st[i] = (m_q[i].size() == DEPTH);
      end
      exp_q.push_back(m_out);
    end
  end

  // ---------------- scoreboard compare ----------------
  snap_t c_e;
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      c_e = exp_q.pop_front();
      chk("wr_out_valid", bus.wr_out_valid, c_e.wv);
      if (c_e.wv || !nRST) begin
        chk("wr_out_src",   bus.wr_out_src,   c_e.ws);
        chk("wr_out_desc",  bus.wr_out_desc,  c_e.wd);
        chk("wr_out_wdata", bus.wr_out_wdata, c_e.wx);
      end
      chk("rd_out_valid", bus.rd_out_valid, c_e.rv);
      if (c_e.rv || !nRST) begin
        chk("rd_out_src",  bus.rd_out_src,  c_e.rs);
        chk("rd_out_desc", bus.rd_out_desc, c_e.rd);
      end
      chk("req_stall", bus.req_stall, c_e.st);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    bus.w_stall   = 1'b0;
    bus.r_stall   = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_req(input int i, input logic wr, input logic [DW-1:0] d, input logic [XW-1:0] x);
    bus.req_valid[i]          = 1'b1;
    bus.req_write[i]          = wr;
    bus.req_desc[i*DW +: DW]  = d;
    bus.req_wdata[i*XW +: XW] = x;
  endtask

  // ---------------- stimulus ----------------
  int            first_src0;
  int            exp_first;
  int            k;
  logic          acc0;
  logic [NR-1:0] acc;

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_desc  = '0;
    bus.req_wdata = '0;
    bus.w_stall   = 1'b0;
    bus.r_stall   = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_wr_valid", bus.wr_out_valid, 0);
    chk("rst_rd_valid", bus.rd_out_valid, 0);
    chk("rst_req_stall", bus.req_stall, 0);
    chk("rst_wr_desc", bus.wr_out_desc, 0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Single uncontested write: visible in cycle 2 only.
    set_req(0, 1'b1, 64'h10, 128'hA0);
    step(); bus.req_valid = '0;
    @(negedge CLK); chk("lat_c1_valid", bus.wr_out_valid, 0);
    step(); @(negedge CLK);
    chk("lat_c2_valid", bus.wr_out_valid, 1);
    chk("lat_c2_src", bus.wr_out_src, 0);
    chk("lat_c2_desc", bus.wr_out_desc, 64'h10);
    step(); @(negedge CLK); chk("lat_c3_valid", bus.wr_out_valid, 0);
    idle(2);

    // Two writes in the same cycle: higher index first.
    set_req(0, 1'b1, 64'h20, 128'hB0);
    set_req(1, 1'b1, 64'h21, 128'hB1);
    step(); bus.req_valid = '0;
    step(); @(negedge CLK);
    chk("prio_c2_src", bus.wr_out_src, 1);
    chk("prio_c2_desc", bus.wr_out_desc, 64'h21);
    step(); @(negedge CLK);
    chk("prio_c3_valid", bus.wr_out_valid, 1);
    chk("prio_c3_src", bus.wr_out_src, 0);
    idle(3);

    // Write and read from different requesters grant together.
    set_req(1, 1'b1, 64'h41, 128'hC1);
    set_req(0, 1'b0, 64'h40, 128'h0);
    step(); bus.req_valid = '0;
    step(); @(negedge CLK);
    chk("dual_wr_valid", bus.wr_out_valid, 1);
    chk("dual_wr_src", bus.wr_out_src, 1);
    chk("dual_rd_valid", bus.rd_out_valid, 1);
    chk("dual_rd_src", bus.rd_out_src, 0);
    chk("dual_rd_desc", bus.rd_out_desc, 64'h40);
    idle(3);

    // Write stall in cycles 2-4 while req0 keeps pushing.
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) set_req(0, 1'b1, 64'h30 + 64'(k), 128'(k));
      else bus.req_valid = '0;
      bus.w_stall = (c >= 2 && c <= 4);
      @(negedge CLK);
      if (c >= 2 && c <= 4) begin
        chk("hold_valid", bus.wr_out_valid, 1);
        chk("hold_desc", bus.wr_out_desc, 64'h30);
      end
      if (c == 3) chk("hold_req_stall0", bus.req_stall[0], 1);
      acc0 = bus.req_valid[0] && !bus.req_stall[0];
      step();
      if (acc0) k++;
    end
    idle(4);

    // Starvation: req1 streams writes, req0 issues one.
    first_src0 = -1;
    for (int c = 0; c < 24; c++) begin
      bus.req_valid = '0;
      if (c < 12) set_req(1, 1'b1, 64'h100 + 64'(c), 128'(c));
      if (c == 0) set_req(0, 1'b1, 64'h50, 128'h55);
      @(negedge CLK);
      if (first_src0 < 0 && bus.wr_out_valid && bus.wr_out_src == 1'b0) first_src0 = c;
      step();
    end
`ifdef SPAD_REQ_ARB_AGING_EN
    exp_first = LIMIT + 2;
`else
    exp_first = 12 + 2;
`endif
    chk("starve_first_src0", first_src0, exp_first);
    idle(3);

    // Random traffic with random downstream backpressure.
    acc = '1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 9) < 7);
          bus.req_write[i] = 1'($urandom_range(0, 1));
          bus.req_desc[i*DW +: DW]  = {$urandom, $urandom};
          bus.req_wdata[i*XW +: XW] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      bus.w_stall = ($urandom_range(0, 3) == 0);
      bus.r_stall = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      acc = bus.req_valid & ~bus.req_stall;
      step();
    end
    idle(4);

    // Fill both FIFOs behind a stalled channel, then reset mid-operation.
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1'b1, 64'h60 + 64'(c), 128'(c));
      set_req(1, 1'b1, 64'h70 + 64'(c), 128'(c));
      bus.w_stall = (c >= 2);
      bus.r_stall = 1'b1;
      step();
    end
    @(negedge CLK);
    chk("full_req_stall", bus.req_stall, 2'b11);
    chk("full_wr_valid", bus.wr_out_valid, 1);
    step();
    nRST = 1'b0;
    #1;
    chk("arst_wr_valid", bus.wr_out_valid, 0);
    chk("arst_wr_desc", bus.wr_out_desc, 0);
    chk("arst_rd_valid", bus.rd_out_valid, 0);
    chk("arst_req_stall", bus.req_stall, 0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    bus.req_valid = '0;
    bus.w_stall   = 1'b0;
    bus.r_stall   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("post_rst_wr_valid", bus.wr_out_valid, 0);
      chk("post_rst_rd_valid", bus.rd_out_valid, 0);
      step();
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
